cdt_frame_receiver: RTL

CDT_FRAME_RECEIVER -- requirements
Module: cdt_frame_receiver

---
 rtl/cdt_frame_receiver.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/cdt_frame_receiver.sv
// -----------------------------------------------------------------------------
// cdt_frame_receiver
//
// Recovers fixed-length frames from the unqualified CDT word stream and
// replays each frame's payload over a valid/ready interface.
//
// The incoming stream has no framing strobe. Every word is written into the
// current write bank. A frame is recognised when a trailer marker is followed
// directly by a crate word that matches crateID. The PAYLOAD words that arrived
// just before that trailer are the frame payload.
//
// There are two banks. While one bank is being replayed, the other keeps
// filling. A frame that completes while the reader is still busy is dropped.
// The bank being replayed is never overwritten.
//
// Ports
//   clk         : sole clock, rising edge
//   reset       : synchronous, active-low
//   din         : packed 16-bit word stream, one word per clock
//   crateID     : expected crate number (static)
//   dout        : payload word presented to the consumer
//   dout_valid  : dout holds a payload word
//   dout_ready  : consumer accepts dout when dout_valid is high
//   dout_last   : marks the final payload word of a frame
//   dout_crate  : crate number of the frame being read out
//   frame_count : accepted frames (saturating)
//   drop_count  : valid frames discarded because the reader was busy (saturating)
//   err_count   : rejected trailer candidates (saturating)
// -----------------------------------------------------------------------------
module cdt_frame_receiver #(
    parameter int          PAYLOAD = 49,
    parameter logic [15:0] TRAILER = 16'h5555,
    parameter int          DEPTH   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic [4:0]  crateID,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic [4:0]  dout_crate,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PAY_A    = AW'(PAYLOAD);
    localparam logic [AW-1:0] LAST_IDX = AW'(PAYLOAD - 1);
    localparam logic [AW-1:0] FCNT_MAX = AW'(DEPTH - 1);

    typedef enum logic {HUNT, TRAIL} hunt_t;
    typedef enum logic {RIDLE, RSEND} read_t;

    // Storage: two banks, selected by wbank (writer) and rbank (reader)
    logic [15:0] mem [2][DEPTH];

    hunt_t         hunt_state, hunt_next;
    read_t         read_state, read_next;
    logic          wbank, rbank;
    logic [AW-1:0] wptr;
    logic [AW-1:0] fcnt;
    logic [AW-1:0] ta;
    logic [AW-1:0] raddr;
    logic [AW-1:0] ridx;

    logic is_trailer, enough, crate_ok;
    logic xfer, last_xfer;
    logic latch_ta, frame_ok, cand_err, accept, drop;

    // Writer: every word goes into the write bank, whatever it is. Words
    // arriving during reset are discarded, so nothing stale is ever replayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[wbank][wptr] <= din;
        end
    end

    // Next-state logic for the hunt and reader FSMs.
    //
    // The hunt FSM arms on a trailer only after at least PAYLOAD words are
    // in the bank. It then judges the following word as a crate word. A
    // repeated trailer re-arms on the newer marker.
    //
    // A valid frame is accepted only if the reader can take the bank now:
    // either the reader is idle, or it is handing over its final word in
    // this same cycle. Otherwise the frame is dropped.
    always_comb begin
        hunt_next  = hunt_state;
        read_next  = read_state;
        latch_ta   = 1'b0;
        frame_ok   = 1'b0;
        cand_err   = 1'b0;

        is_trailer = (din == TRAILER);
        enough     = (fcnt >= PAY_A);
        crate_ok   = (din[15:5] == 11'd0) && (din[4:0] == crateID);
        xfer       = (read_state == RSEND) && dout_ready;
        last_xfer  = xfer && (ridx == LAST_IDX);

        case (hunt_state)
            HUNT: begin
                if (is_trailer && enough) begin
                    hunt_next = TRAIL;
                    latch_ta  = 1'b1;
                end
            end
            TRAIL: begin
                if (is_trailer) begin
                    if (enough) begin
                        latch_ta = 1'b1;
                    end else begin
                        hunt_next = HUNT;
                    end
                end else begin
                    hunt_next = HUNT;
                    if (crate_ok) begin
                        frame_ok = 1'b1;
                    end else begin
                        cand_err = 1'b1;
                    end
                end
            end
            default: hunt_next = HUNT;
        endcase

        accept = frame_ok && ((read_state == RIDLE) || last_xfer);
        drop   = frame_ok && !accept;

        case (read_state)
            RIDLE: begin
                if (accept) begin
                    read_next = RSEND;
                end
            end
            RSEND: begin
                if (last_xfer && !accept) begin
                    read_next = RIDLE;
                end
            end
            default: read_next = RIDLE;
        endcase
    end

    // Output presentation. The read address moves only on a transfer, and
    // the read bank is never written while it is being replayed. As a
    // result, dout holds steady through a stall.
    always_comb begin
        dout_valid = (read_state == RSEND);
        dout_last  = dout_valid && (ridx == LAST_IDX);
        dout       = dout_valid ? mem[rbank][raddr] : 16'd0;
    end

    // State registers, pointers and counters.
    //
    // On any valid frame, the write pointer and fill count restart. This
    // happens whether the frame is accepted or dropped. On acceptance, the
    // banks swap, and the reader starts PAYLOAD words before the trailer.
    // The address wraps modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hunt_state  <= HUNT;
            read_state  <= RIDLE;
            wbank       <= 1'b0;
            rbank       <= 1'b0;
            wptr        <= '0;
            fcnt        <= '0;
            ta          <= '0;
            raddr       <= '0;
            ridx        <= '0;
            dout_crate  <= 5'd0;
            frame_count <= 16'd0;
            drop_count  <= 8'd0;
            err_count   <= 8'd0;
        end else begin
            hunt_state <= hunt_next;
            read_state <= read_next;

            if (latch_ta) begin
                ta <= wptr;
            end

            if (frame_ok) begin
                wptr <= '0;
                fcnt <= '0;
            end else begin
                wptr <= wptr + 1'b1;
                if (fcnt != FCNT_MAX) begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            if (accept) begin
                rbank      <= wbank;
                wbank      <= ~wbank;
                raddr      <= ta - PAY_A;
                ridx       <= '0;
                dout_crate <= din[4:0];
                if (frame_count != 16'hFFFF) begin
                    frame_count <= frame_count + 16'd1;
                end
            end else if (xfer) begin
                raddr <= raddr + 1'b1;
                ridx  <= ridx + 1'b1;
            end

            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            if (cand_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
